// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC register write port, issues in-order imem
// requests under a credit limit, tags responses with their address and buffers them for decode.
module fetch_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_pc_curr,
    output logic            o_pc_write,
    output logic [XLEN-1:0] o_pc_next,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_inst_valid,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Pending-address FIFO: fetch addresses of granted requests awaiting a response
    logic [XLEN-1:0] pend_mem_q [DEPTH];
    logic [XLEN-1:0] pend_mem_d [DEPTH];
    logic [PW-1:0]   pend_wr_q, pend_wr_d;
    logic [PW-1:0]   pend_rd_q, pend_rd_d;
    logic [CW-1:0]   pend_q, pend_d;

    // Instruction FIFO: {instruction, fetch address} pairs presented to decode
    logic [31:0]     inst_mem_q [DEPTH];
    logic [31:0]     inst_mem_d [DEPTH];
    logic [XLEN-1:0] ipc_mem_q  [DEPTH];
    logic [XLEN-1:0] ipc_mem_d  [DEPTH];
    logic [PW-1:0]   inst_wr_q, inst_wr_d;
    logic [PW-1:0]   inst_rd_q, inst_rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Responses still owed by memory for requests made before the last redirect
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW+1:0]   used;
    logic [CW:0]     drop_sum;
    logic            credit_ok;
    logic            req;
    logic            accept;
    logic            rsp_take;
    logic            rsp_drop;
    logic            inst_pop;

    // Every slot is reserved at grant time, so neither FIFO can overflow.
    assign used      = (CW+2)'(pend_q) + (CW+2)'(drop_q) + (CW+2)'(cnt_q);
    assign credit_ok = used < (CW+2)'(DEPTH);
    assign req       = i_rst_n & ~i_redirect & credit_ok;
    assign accept    = req & i_imem_gnt;
    assign rsp_drop  = i_imem_rvalid & ~i_redirect & (drop_q != '0);
    assign rsp_take  = i_imem_rvalid & ~i_redirect & (drop_q == '0) & (pend_q != '0);
    assign inst_pop  = (cnt_q != '0) & i_inst_ready;
    assign drop_sum  = (CW+1)'(pend_q) + (CW+1)'(drop_q);

    assign o_imem_req   = req;
    assign o_imem_addr  = i_pc_curr;
    assign o_inst_valid = (cnt_q != '0);
    assign o_inst       = inst_mem_q[inst_rd_q];
    assign o_inst_pc    = ipc_mem_q[inst_rd_q];

    always_comb begin
        o_pc_write = 1'b0;
        o_pc_next  = i_pc_curr;
        if (i_rst_n && i_redirect) begin
            o_pc_write = 1'b1;
            o_pc_next  = i_redirect_pc;
        end else if (accept) begin
            o_pc_write = 1'b1;
            o_pc_next  = i_pc_curr + XLEN'(4);
        end
    end

    always_comb begin
        pend_mem_d = pend_mem_q;
        inst_mem_d = inst_mem_q;
        ipc_mem_d  = ipc_mem_q;
        pend_wr_d  = pend_wr_q;
        pend_rd_d  = pend_rd_q;
        pend_d     = pend_q;
        inst_wr_d  = inst_wr_q;
        inst_rd_d  = inst_rd_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;

        if (i_redirect) begin
            pend_wr_d = '0;
            pend_rd_d = '0;
            pend_d    = '0;
            inst_wr_d = '0;
            inst_rd_d = '0;
            cnt_d     = '0;
            // Everything in flight becomes stale; a response landing now is already gone.
            drop_d    = CW'(drop_sum - (((i_imem_rvalid == 1'b1) && (drop_sum != '0)) ? (CW+1)'(1) : '0));
        end else begin
            if (accept) begin
                pend_mem_d[pend_wr_q] = i_pc_curr;
                pend_wr_d             = pend_wr_q + PW'(1);
            end
            if (rsp_take) begin
                inst_mem_d[inst_wr_q] = i_imem_rdata;
                ipc_mem_d[inst_wr_q]  = pend_mem_q[pend_rd_q];
                pend_rd_d             = pend_rd_q + PW'(1);
                inst_wr_d             = inst_wr_q + PW'(1);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (inst_pop) begin
                inst_rd_d = inst_rd_q + PW'(1);
            end
            pend_d = pend_q + CW'(accept) - CW'(rsp_take);
            cnt_d  = cnt_q + CW'(rsp_take) - CW'(inst_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_wr_q <= '0;
            pend_rd_q <= '0;
            pend_q    <= '0;
            inst_wr_q <= '0;
            inst_rd_q <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
        end else begin
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            pend_q    <= pend_d;
            inst_wr_q <= inst_wr_d;
            inst_rd_q <= inst_rd_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: occupancy counts alone decide what is valid.
    always_ff @(posedge i_clk) begin
        pend_mem_q <= pend_mem_d;
        inst_mem_q <= inst_mem_d;
        ipc_mem_q  <= ipc_mem_d;
    end

    a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rvalid |-> ((pend_q != '0) || (drop_q != '0)));

    a_credit_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        used <= (CW+2)'(DEPTH));

endmodule
